instr_sequencer: RTL and testbench

//  Instruction fetch/issue front end for the matrix execution engine. Reads 5-bit instruction words from instruction memory.

---
 rtl/matrix_pkg.sv | 28 ++
 rtl/seq_watchdog.sv | 33 +++
 rtl/instr_sequencer.sv | 113 +++++++++++
 tb/tb_instr_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: constants shared by the matrix-engine sequencer and decoder.
//   - opcode encodings (3-bit, instruction bits [4:2])
//   - instruction word field positions
//   - op_is_legal(): true for opcodes that map to a functional unit
package matrix_pkg;

  localparam int INSTR_W = 5;
  localparam int OP_HI   = 4;
  localparam int OP_LO   = 2;
  localparam int WR_BIT  = 1;  // write_to
  localparam int RD_BIT  = 0;  // read_from

  typedef logic [OP_HI-OP_LO:0] opcode_t;

  localparam opcode_t OP_ADD       = 3'b000;
  localparam opcode_t OP_SUB       = 3'b001;
  localparam opcode_t OP_SCALE     = 3'b010;
  localparam opcode_t OP_MULT      = 3'b011;
  localparam opcode_t OP_TRANSPOSE = 3'b100;
  localparam opcode_t OP_STOP      = 3'b111;

  // STOP is not a unit op; 101/110 are unassigned.
  function automatic logic op_is_legal(opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SCALE) ||
           (op == OP_MULT) || (op == OP_TRANSPOSE);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: counts cycles spent waiting for a functional unit.
//   clk, reset (async, active-high)
//   clear   : zero the count (start of a new wait)
//   enable  : count this cycle
//   expired : count has reached TIMEOUT-1, i.e. this is the last
//             permitted waiting cycle
// The counter saturates at TIMEOUT and never wraps.
module seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (count != CW'(TIMEOUT)))
      count <= count + 1'b1;
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: instruction fetch/issue front end for the matrix engine.
//   clk, reset (async, active-high)
//   start       : pulse, begin at START_ADDR (IDLE/HALT/ERR only)
//   imem_rd/imem_addr/imem_rdata : instruction memory, 1-cycle read latency
//   instr       : current instruction word, instr_valid strobes once on issue
//   unit_done   : functional unit finished the issued instruction
//   pc, busy, halted, error : status
// Optional build macro SEQ_SINGLE_STEP_EN adds step_mode/step inputs and a
// PAUSE state entered in place of every FETCH while step_mode is high.
module instr_sequencer
  import matrix_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [4:0]        imem_rdata,
  output logic [4:0]        instr,
  output logic              instr_valid,
  input  logic              unit_done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              error
`ifdef SEQ_SINGLE_STEP_EN
  ,
  input  logic              step_mode,
  input  logic              step
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_MEM, S_ISSUE, S_WAIT_DONE, S_HALT, S_ERR, S_PAUSE
  } state_t;

  state_t  state;
  state_t  fetch_tgt;
  opcode_t rd_op;
  logic    wd_expired;

  assign rd_op = imem_rdata[OP_HI:OP_LO];

  // Every path toward FETCH goes through this, so single-step only has to
  // redirect it in one place.
`ifdef SEQ_SINGLE_STEP_EN
  assign fetch_tgt = step_mode ? S_PAUSE : S_FETCH;
`else
  assign fetch_tgt = S_FETCH;
`endif

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == S_ISSUE),
    .enable  ((state == S_WAIT_DONE) && !unit_done),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
      instr <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT, S_ERR:
          if (start) begin
            pc    <= ADDR_W'(START_ADDR);
            state <= fetch_tgt;
          end
        S_FETCH:
          state <= S_WAIT_MEM;
        S_WAIT_MEM: begin
          instr <= imem_rdata;
          if (rd_op == OP_STOP)      state <= S_HALT;
          else if (!op_is_legal(rd_op)) state <= S_ERR;
          else                       state <= S_ISSUE;
        end
        S_ISSUE, S_WAIT_DONE:
          // pc wraps silently at 2**ADDR_W
          if (unit_done) begin
            pc    <= pc + 1'b1;
            state <= fetch_tgt;
          end else if (state == S_ISSUE) begin
            state <= S_WAIT_DONE;
          end else if (wd_expired) begin
            state <= S_ERR;
          end
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE:
          if (step) state <= S_FETCH;
`endif
        default:
          state <= S_IDLE;
      endcase
    end
  end

  assign imem_rd     = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_ISSUE);
  assign busy        = (state == S_FETCH) || (state == S_WAIT_MEM) ||
                       (state == S_ISSUE) || (state == S_WAIT_DONE) ||
                       (state == S_PAUSE);
  assign halted      = (state == S_HALT);
  assign error       = (state == S_ERR);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer. DUT a: ADDR_W=8, START_ADDR=0, TIMEOUT=8.
// DUT b: ADDR_W=2, START_ADDR=3, TIMEOUT=8 (PC wrap case).
// Every issue strobe is checked against a queue of expected {pc, instr};
// status outputs are checked at hand-computed cycles.
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT a
  logic       start, unit_done, imem_rd, instr_valid, busy, halted, error;
  logic [7:0] imem_addr, pc;
  logic [4:0] imem_rdata = '0;
  logic [4:0] instr;
  logic [4:0] mem [256];
  logic       step_mode, step;
  logic [12:0] exp_q [$];

  // DUT b
  logic       start2, done2, imem_rd2, instr_valid2, busy2, halted2, error2;
  logic [1:0] imem_addr2, pc2;
  logic [4:0] imem_rdata2 = '0;
  logic [4:0] instr2;
  logic [4:0] mem2 [4];
  logic       step_mode2 = 1'b0;
  logic       step2 = 1'b0;
  logic [12:0] exp_q2 [$];

  instr_sequencer #(.ADDR_W(8), .START_ADDR(0), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset), .start(start),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .unit_done(unit_done),
    .pc(pc), .busy(busy), .halted(halted), .error(error)
`ifdef SEQ_SINGLE_STEP_EN
    , .step_mode(step_mode), .step(step)
`endif
  );

  instr_sequencer #(.ADDR_W(2), .START_ADDR(3), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset(reset), .start(start2),
    .imem_rd(imem_rd2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .instr(instr2), .instr_valid(instr_valid2), .unit_done(done2),
    .pc(pc2), .busy(busy2), .halted(halted2), .error(error2)
`ifdef SEQ_SINGLE_STEP_EN
    , .step_mode(step_mode2), .step(step2)
`endif
  );

  // instruction memories, one-cycle read latency
  always @(posedge clk) if (imem_rd)  imem_rdata  <= mem[imem_addr];
  always @(posedge clk) if (imem_rd2) imem_rdata2 <= mem2[imem_addr2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (!reset && instr_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL issue_a: unexpected instr_valid pc=%0h instr=%b", pc, instr);
      end else begin
        chk("issue_a", {pc, instr}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && instr_valid2) begin
      if (exp_q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL issue_b: unexpected instr_valid pc=%0h instr=%b", pc2, instr2);
      end else begin
        chk("issue_b", {6'd0, pc2, instr2}, exp_q2.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; unit_done = 1'b0; step_mode = 1'b0; step = 1'b0;
    start2 = 1'b0; done2 = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 5'b11100;
    for (int i = 0; i < 4; i++) mem2[i] = 5'b11100;

    // ---- 1: ADD then STOP, latency and halt
    mem[0] = 5'b00000; mem[1] = 5'b11100;
    tick(2);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_flags", {imem_rd, instr_valid, busy, halted, error}, 0);
    chk("rst_b", {pc2, instr2, imem_rd2, instr_valid2, busy2, halted2, error2}, 0);
    reset = 1'b0;
    tick();
    exp_q.push_back({8'd0, 5'b00000});
    pulse_start();                                  // cycle 1: FETCH
    chk("t1_fetch", {imem_rd, imem_addr}, {1'b1, 8'd0});
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_novalid_c2", instr_valid, 0);
    tick();                                         // cycle 3: ISSUE
    chk("t1_valid_c3", instr_valid, 1);
    tick(2);
    unit_done = 1'b1; tick(); unit_done = 1'b0;     // done at cycle 5
    tick(2);                                        // cycle 8
    chk("t1_halt", {halted, busy, error}, 3'b100);
    chk("t1_pc", pc, 1);

    // ---- 2: done coincident with issue (start ignored there too)
    mem[0] = 5'b00111;
    exp_q.push_back({8'd0, 5'b00111});
    pulse_start();
    tick(2);                                        // cycle 3: ISSUE
    start = 1'b1; unit_done = 1'b1; tick(); start = 1'b0; unit_done = 1'b0;
    chk("t2_refetch", {imem_rd, imem_addr}, {1'b1, 8'd1});
    chk("t2_instr", instr, 5'b00111);
    tick(2);
    chk("t2_halt", {halted, pc}, {1'b1, 8'd1});

    // ---- 3: watchdog, start while busy ignored, restart from ERR
    mem[0] = 5'b01000;
    exp_q.push_back({8'd0, 5'b01000});
    pulse_start();
    tick(5);
    start = 1'b1; tick(); start = 1'b0;             // cycle 7, WAIT_DONE
    tick(4);                                        // cycle 11: last wait
    chk("t3_wait_last", {busy, error}, 2'b10);
    tick();                                         // cycle 12
    chk("t3_err", {error, busy, halted}, 3'b100);
    chk("t3_pc_instr", {pc, instr}, {8'd0, 5'b01000});
    mem[0] = 5'b00000;
    exp_q.push_back({8'd0, 5'b00000});
    pulse_start();
    chk("t3_restart", {imem_rd, imem_addr, error}, {1'b1, 8'd0, 1'b0});
    tick(2);
    unit_done = 1'b1; tick(); unit_done = 1'b0;
    tick(2);
    chk("t3_halt", {halted, pc}, {1'b1, 8'd1});

    // ---- 4: illegal opcode 101 (unit_done in FETCH is ignored)
    mem[0] = 5'b10100;
    pulse_start();                                  // cycle 1: FETCH
    unit_done = 1'b1; tick(); unit_done = 1'b0;
    chk("t4_noerr_c2", error, 0);
    tick();                                         // cycle 3
    chk("t4_err", {error, busy, halted}, 3'b100);
    chk("t4_pc_instr", {pc, instr}, {8'd0, 5'b10100});

    // ---- 5: async reset during WAIT_DONE, then clean restart
    mem[0] = 5'b00000; mem[1] = 5'b01000; mem[2] = 5'b11100;
    exp_q.push_back({8'd0, 5'b00000});
    exp_q.push_back({8'd1, 5'b01000});
    pulse_start();
    tick(2);
    unit_done = 1'b1; tick(); unit_done = 1'b0;
    tick(3);                                        // WAIT_DONE of pc=1
    chk("t5_pre", {busy, pc}, {1'b1, 8'd1});
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_pc_instr", {pc, instr}, 0);
    chk("t5_rst_flags", {imem_rd, instr_valid, busy, halted, error}, 0);
    tick(); reset = 1'b0;
    tick();
    exp_q.push_back({8'd0, 5'b00000});
    exp_q.push_back({8'd1, 5'b01000});
    pulse_start();
    chk("t5_refetch", {imem_rd, imem_addr}, {1'b1, 8'd0});
    tick(2);
    unit_done = 1'b1; tick(); unit_done = 1'b0;
    tick(2);
    unit_done = 1'b1; tick(); unit_done = 1'b0;
    tick(2);
    chk("t5_halt", {halted, pc}, {1'b1, 8'd2});

    // ---- 6: PC wrap on the narrow instance
    mem2[3] = 5'b01100; mem2[0] = 5'b11100;
    exp_q2.push_back({8'd3, 5'b01100});
    start2 = 1'b1; tick(); start2 = 1'b0;
    chk("t6_fetch", {imem_rd2, imem_addr2}, {1'b1, 2'd3});
    tick(2);
    done2 = 1'b1; tick(); done2 = 1'b0;
    chk("t6_wrap_fetch", {imem_rd2, imem_addr2}, {1'b1, 2'd0});
    tick(2);
    chk("t6_halt", {halted2, error2, pc2}, {1'b1, 1'b0, 2'd0});

`ifdef SEQ_SINGLE_STEP_EN
    // ---- 7: single step
    mem[0] = 5'b00000; mem[1] = 5'b11100;
    step_mode = 1'b1;
    exp_q.push_back({8'd0, 5'b00000});
    pulse_start();
    chk("t7_pause", {imem_rd, busy}, 2'b01);
    tick();
    chk("t7_pause_hold", imem_rd, 0);
    step = 1'b1; tick(); step = 1'b0;
    chk("t7_fetch", {imem_rd, imem_addr}, {1'b1, 8'd0});
    tick(2);
    unit_done = 1'b1; tick(); unit_done = 1'b0;
    chk("t7_pause2", {imem_rd, busy, pc}, {1'b0, 1'b1, 8'd1});
    step = 1'b1; tick(); step = 1'b0;
    chk("t7_fetch2", {imem_rd, imem_addr}, {1'b1, 8'd1});
    tick(2);
    chk("t7_halt", halted, 1);
    step_mode = 1'b0;
`endif

    tick(2);
    chk("queue_a_drained", exp_q.size(), 0);
    chk("queue_b_drained", exp_q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
